// File: rtl/fabric_exit_queue.sv
// Store-and-forward egress queue for one fabric output port: admits, drops or discards
// crossbar frames and releases only committed good frames. Optional counters: FABRIC_EXIT_QUEUE_STATS_EN.
module fabric_exit_queue #(
    parameter int DEPTH           = 256,
    parameter int MAX_FRAME_WORDS = 190
) (
    input  logic        clk_fabric,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic [15:0] frames_queued,
    output logic        drop_pulse,
    output logic [1:0]  dbg_state
`ifdef FABRIC_EXIT_QUEUE_STATS_EN
    ,
    input  logic        stat_clear,
    output logic [31:0] stat_frames_tx,
    output logic [31:0] stat_drops_full,
    output logic [31:0] stat_drops_bad
`endif
);

    // Handshake: a beat transfers on a rising edge where valid && ready; the source holds
    // its payload stable while valid is high and ready is low. s_tready is tied high.

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAX_P   = (AW+1)'(MAX_FRAME_WORDS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STORE   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [72:0] r_mem [DEPTH];

    logic [1:0]  r_state;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_wr_commit;
    logic [AW:0] r_rd_ptr;
    logic        r_drop_pulse;
    logic [15:0] r_frames_queued;

    logic [72:0] r_ram_q;
    logic        r_ram_vld;
    logic [72:0] r_out;
    logic [72:0] r_skid;
    logic [1:0]  r_cnt;

    logic [1:0]  w_nxt_state;
    logic [AW:0] w_free;
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_commit_nxt;
    logic        w_wr_en;
    logic        w_commit;
    logic        w_drop_full;
    logic        w_drop_bad;
    logic        w_pop;
    logic        w_tx_last;
    logic        w_avail;
    logic [2:0]  w_occ;
    logic [2:0]  w_lim;
    logic        w_rd_en;

    // Words handed to the prefetch stage count as freed, so free tracks rd_ptr.
    assign w_free = DEPTH_P - (r_wr_ptr - r_rd_ptr);

    always_comb begin
        w_nxt_state  = r_state;
        w_wr_en      = 1'b0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_wr_commit;
        w_commit     = 1'b0;
        w_drop_full  = 1'b0;
        w_drop_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_tvalid) begin
                    if (w_free >= MAX_P) begin
                        w_wr_en = 1'b1;
                        if (s_tlast) begin
                            if (s_tuser) begin
                                w_drop_bad = 1'b1;
                            end else begin
                                w_commit     = 1'b1;
                                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                                w_commit_nxt = r_wr_ptr + 1'b1;
                            end
                        end else begin
                            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                            w_nxt_state  = ST_STORE;
                        end
                    end else begin
                        w_drop_full = 1'b1;
                        if (!s_tlast) w_nxt_state = ST_DISCARD;
                    end
                end
            end
            ST_STORE: begin
                if (s_tvalid) begin
                    if (w_free == '0) begin
                        w_drop_full  = 1'b1;
                        w_wr_ptr_nxt = r_wr_commit;
                        w_nxt_state  = s_tlast ? ST_IDLE : ST_DISCARD;
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_tlast) begin
                            w_nxt_state = ST_IDLE;
                            if (s_tuser) begin
                                w_drop_bad   = 1'b1;
                                w_wr_ptr_nxt = r_wr_commit;
                            end else begin
                                w_commit     = 1'b1;
                                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                                w_commit_nxt = r_wr_ptr + 1'b1;
                            end
                        end else begin
                            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (s_tvalid && s_tlast) w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_wr_commit  <= w_commit_nxt;
            r_drop_pulse <= w_drop_full | w_drop_bad;
        end
    end

    assign w_pop     = m_tvalid && m_tready;
    assign w_tx_last = w_pop && r_out[72];
    assign w_avail   = (r_rd_ptr != r_wr_commit);
    // Issue a read only if the word still has a slot when it lands next cycle.
    assign w_occ     = {1'b0, r_cnt} + {2'b00, r_ram_vld};
    assign w_lim     = 3'd1 + {2'b00, w_pop};
    assign w_rd_en   = w_avail && (w_occ <= w_lim);

    always_ff @(posedge clk_fabric) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        if (w_rd_en) r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
        end else begin
            r_ram_vld <= w_rd_en;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // r_out is the head presented on m_*, r_skid catches the word in flight during a stall.
    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (r_ram_vld) begin
                        r_out <= r_ram_q;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && r_ram_vld) begin
                        r_out <= r_ram_q;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end else if (r_ram_vld) begin
                        r_skid <= r_ram_q;
                        r_cnt  <= 2'd2;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_out <= r_skid;
                        if (r_ram_vld) r_skid <= r_ram_q;
                        else r_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_fabric) begin
        if (rst) begin
            r_frames_queued <= '0;
        end else begin
            case ({w_commit, w_tx_last})
                2'b10:   r_frames_queued <= r_frames_queued + 16'd1;
                2'b01:   r_frames_queued <= r_frames_queued - 16'd1;
                default: r_frames_queued <= r_frames_queued;
            endcase
        end
    end

`ifdef FABRIC_EXIT_QUEUE_STATS_EN
    logic [31:0] r_stat_tx;
    logic [31:0] r_stat_full;
    logic [31:0] r_stat_bad;

    always_ff @(posedge clk_fabric) begin
        if (rst || stat_clear) begin
            r_stat_tx   <= '0;
            r_stat_full <= '0;
            r_stat_bad  <= '0;
        end else begin
            if (w_tx_last && (r_stat_tx != '1))     r_stat_tx   <= r_stat_tx + 32'd1;
            if (w_drop_full && (r_stat_full != '1)) r_stat_full <= r_stat_full + 32'd1;
            if (w_drop_bad && (r_stat_bad != '1))   r_stat_bad  <= r_stat_bad + 32'd1;
        end
    end

    assign stat_frames_tx  = r_stat_tx;
    assign stat_drops_full = r_stat_full;
    assign stat_drops_bad  = r_stat_bad;
`endif

    assign s_tready      = 1'b1;
    assign m_tvalid      = (r_cnt != 2'd0);
    assign m_tlast       = r_out[72];
    assign m_tkeep       = r_out[71:64];
    assign m_tdata       = r_out[63:0];
    assign frames_queued = r_frames_queued;
    assign drop_pulse    = r_drop_pulse;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_fabric_exit_queue.sv
// Directed bench for fabric_exit_queue: frame table, latency, overflow/truncate,
// wrap-around with random backpressure, mid-frame reset and (if enabled) statistics.
module tb_fabric_exit_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tuser;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic [15:0] frames_queued;
    logic        drop_pulse;
    logic [1:0]  dbg_state;
`ifdef FABRIC_EXIT_QUEUE_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_frames_tx;
    logic [31:0] stat_drops_full;
    logic [31:0] stat_drops_bad;
`endif

    fabric_exit_queue #(.DEPTH(256), .MAX_FRAME_WORDS(190)) dut (
        .clk_fabric    (clk),
        .rst           (rst),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tuser       (s_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .frames_queued (frames_queued),
        .drop_pulse    (drop_pulse),
        .dbg_state     (dbg_state)
`ifdef FABRIC_EXIT_QUEUE_STATS_EN
        ,
        .stat_clear      (stat_clear),
        .stat_frames_tx  (stat_frames_tx),
        .stat_drops_full (stat_drops_full),
        .stat_drops_bad  (stat_drops_bad)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int out_beats = 0;
    int drop_cnt  = 0;
    int frame_id  = 0;
    logic rand_en   = 1'b0;
    logic rdy_fixed = 1'b1;
    logic [72:0] exp_q[$];

    // Sole driver of m_tready: fixed level or 50% random per cycle.
    always @(posedge clk) begin
        #2;
        m_tready = rand_en ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and AXI hold check, sampled mid-cycle ahead of the edge that transfers.
    logic        hold_pend = 1'b0;
    logic [72:0] hold_v;
    always @(negedge clk) begin
        logic [72:0] got;
        logic [72:0] w;
        got = {m_tlast, m_tkeep, m_tdata};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (drop_pulse) drop_cnt++;
            if (hold_pend && m_tvalid) begin
                n_tests++;
                if (got !== hold_v) begin
                    n_fail++;
                    $display("FAIL axi_hold: got 0x%0h expected 0x%0h", got, hold_v);
                end
            end
            hold_pend = m_tvalid && !m_tready;
            hold_v    = got;
            if (m_tvalid && m_tready) begin
                out_beats++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", got);
                end else begin
                    w = exp_q.pop_front();
                    if (got !== w) begin
                        n_fail++;
                        $display("FAIL beat: got 0x%0h expected 0x%0h", got, w);
                    end
                end
            end
        end
    end

    task automatic send_frame(input int len, input logic [7:0] lk, input logic bad, input logic push_exp);
        for (int b = 0; b < len; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {16'(frame_id), 16'(b), $urandom()};
            s_tlast  = (b == len - 1);
            s_tkeep  = s_tlast ? lk : 8'hFF;
            s_tuser  = s_tlast ? bad : 1'b0;
            if (push_exp) exp_q.push_back({s_tlast, s_tkeep, s_tdata});
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        frame_id++;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", longint'(n >= budget), 0);
        repeat (4) tick();
    endtask

    typedef struct {
        int         len;
        logic [7:0] lk;
        logic       bad;
        int         exp_beats;
        int         exp_drops;
    } vec_t;
    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{len: 1,   lk: 8'h01, bad: 1'b0, exp_beats: 1,   exp_drops: 0};
        vecs[1] = '{len: 5,   lk: 8'hFF, bad: 1'b1, exp_beats: 0,   exp_drops: 1};
        vecs[2] = '{len: 3,   lk: 8'hFF, bad: 1'b0, exp_beats: 3,   exp_drops: 0};
        vecs[3] = '{len: 1,   lk: 8'h03, bad: 1'b1, exp_beats: 0,   exp_drops: 1};
        vecs[4] = '{len: 16,  lk: 8'h7F, bad: 1'b0, exp_beats: 16,  exp_drops: 0};
        vecs[5] = '{len: 190, lk: 8'h1F, bad: 1'b0, exp_beats: 190, exp_drops: 0};
        vecs[6] = '{len: 9,   lk: 8'h3F, bad: 1'b0, exp_beats: 9,   exp_drops: 0};

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = 1'b0;
`ifdef FABRIC_EXIT_QUEUE_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_m_tvalid", longint'(m_tvalid), 0);
        chk("rst_frames_queued", longint'(frames_queued), 0);
        chk("rst_drop_pulse", longint'(drop_pulse), 0);
        chk("rst_s_tready", longint'(s_tready), 1);
        chk("rst_m_payload", longint'({m_tlast, m_tkeep, m_tdata[31:0]}), 0);
        chk("rst_state", longint'(dbg_state), 0);
        tick();

        // 8-beat frame: commit, then first m_tvalid three clocks from the commit cycle.
        out_beats = 0; drop_cnt = 0;
        send_frame(8, 8'h0F, 1'b0, 1'b1);
        chk("fq_after_commit", longint'(frames_queued), 1);
        n = 0;
        while (!m_tvalid && n < 10) begin
            tick();
            n++;
        end
        chk("first_valid_latency", longint'(n + 1), 3);
        wait_drain(100);
        chk("single_beats", out_beats, 8);
        chk("single_fq_end", longint'(frames_queued), 0);
        chk("single_drops", drop_cnt, 0);

        for (int i = 0; i < 7; i++) begin
            out_beats = 0; drop_cnt = 0;
            send_frame(vecs[i].len, vecs[i].lk, vecs[i].bad, !vecs[i].bad);
            wait_drain(1000);
            chk($sformatf("vec%0d_beats", i), out_beats, vecs[i].exp_beats);
            chk($sformatf("vec%0d_drops", i), drop_cnt, vecs[i].exp_drops);
            chk($sformatf("vec%0d_fq", i), longint'(frames_queued), 0);
        end

        // Backpressure: first 200-word frame held, second refused at admission.
        rdy_fixed = 1'b0; out_beats = 0; drop_cnt = 0;
        repeat (2) tick();
        send_frame(200, 8'hFF, 1'b0, 1'b1);
        send_frame(200, 8'h0F, 1'b0, 1'b0);
        repeat (5) tick();
        chk("ovf_no_beats", out_beats, 0);
        chk("ovf_drops", drop_cnt, 1);
        chk("ovf_fq", longint'(frames_queued), 1);
        chk("ovf_valid_held", longint'(m_tvalid), 1);
        rdy_fixed = 1'b1;
        wait_drain(1000);
        chk("ovf_beats_out", out_beats, 200);
        chk("ovf_fq_end", longint'(frames_queued), 0);

        // A 260-word frame overruns the empty RAM and is truncated away.
        rdy_fixed = 1'b0; out_beats = 0; drop_cnt = 0;
        repeat (2) tick();
        send_frame(260, 8'hFF, 1'b0, 1'b0);
        repeat (5) tick();
        chk("trunc_drops", drop_cnt, 1);
        chk("trunc_fq", longint'(frames_queued), 0);
        chk("trunc_valid", longint'(m_tvalid), 0);
        rdy_fixed = 1'b1;
        send_frame(12, 8'h07, 1'b0, 1'b1);
        wait_drain(200);
        chk("trunc_next_beats", out_beats, 12);

        // Wrap-around: 50 x 37-word frames with random backpressure.
        out_beats = 0; drop_cnt = 0; rand_en = 1'b1;
        for (int f = 0; f < 50; f++) begin
            n = 0;
            while (frames_queued > 16'd1 && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) chk("wrap_space_timeout", longint'(n), 0);
            send_frame(37, 8'hFF >> $urandom_range(0, 7), 1'b0, 1'b1);
        end
        rand_en = 1'b0; rdy_fixed = 1'b1;
        wait_drain(5000);
        chk("wrap_beats", out_beats, 50 * 37);
        chk("wrap_drops", drop_cnt, 0);
        chk("wrap_fq", longint'(frames_queued), 0);

        // Reset mid-frame with a committed frame waiting.
        rdy_fixed = 1'b0;
        repeat (2) tick();
        send_frame(6, 8'hFF, 1'b0, 1'b1);
        repeat (4) tick();
        chk("prerst_valid", longint'(m_tvalid), 1);
        chk("prerst_fq", longint'(frames_queued), 1);
        for (int b = 0; b < 5; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = {16'(frame_id), 16'(b), 32'h0BAD_0BAD};
            s_tkeep  = 8'hFF;
            s_tlast  = 1'b0;
            s_tuser  = 1'b0;
            if (b == 4) rst = 1'b1;
            tick();
        end
        exp_q.delete();
        chk("midrst_valid", longint'(m_tvalid), 0);
        chk("midrst_fq", longint'(frames_queued), 0);
        chk("midrst_drop", longint'(drop_pulse), 0);
        chk("midrst_state", longint'(dbg_state), 0);
        chk("midrst_tdata", longint'(m_tdata), 0);
        rst = 1'b0; s_tvalid = 1'b0;
        frame_id++;
        rdy_fixed = 1'b1; out_beats = 0; drop_cnt = 0;
        tick();
        send_frame(10, 8'h01, 1'b0, 1'b1);
        wait_drain(200);
        chk("postrst_beats", out_beats, 10);
        chk("postrst_fq", longint'(frames_queued), 0);
        chk("postrst_drops", drop_cnt, 0);

`ifdef FABRIC_EXIT_QUEUE_STATS_EN
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        rdy_fixed = 1'b0;
        repeat (2) tick();
        send_frame(200, 8'hFF, 1'b0, 1'b1);
        send_frame(10, 8'hFF, 1'b0, 1'b0);
        rdy_fixed = 1'b1;
        wait_drain(1000);
        send_frame(4, 8'h0F, 1'b0, 1'b1);
        send_frame(4, 8'h0F, 1'b1, 1'b0);
        send_frame(5, 8'h03, 1'b0, 1'b1);
        wait_drain(200);
        chk("stat_frames_tx", longint'(stat_frames_tx), 3);
        chk("stat_drops_bad", longint'(stat_drops_bad), 1);
        chk("stat_drops_full", longint'(stat_drops_full), 1);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        chk("stat_clear_tx", longint'(stat_frames_tx), 0);
        chk("stat_clear_bad", longint'(stat_drops_bad), 0);
        chk("stat_clear_full", longint'(stat_drops_full), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
